// File: rtl/display_ram_scheduler.sv
// Port-A owner of the display-state RAM: single-word write arbitration plus line-clear row shift.
// Build option RR_ARB_EN selects round-robin write arbitration instead of fixed priority.
module display_ram_scheduler #(
    parameter int unsigned DATA_W           = 30,
    parameter int unsigned ADDR_W           = 12,
    parameter int unsigned LEVEL_LINES_ADDR = 0,
    parameter int unsigned SCORE_ADDR       = 1,
    parameter int unsigned ROW_BASE         = 2,
    parameter int unsigned NUM_ROWS         = 20,
    parameter int unsigned NEXT_ADDR        = 22
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_row_req,
    input  logic [4:0]        i_row_idx,
    input  logic [DATA_W-1:0] i_row_data,
    output logic              o_row_ack,
    input  logic              i_score_req,
    input  logic [DATA_W-1:0] i_score_data,
    output logic              o_score_ack,
    input  logic              i_ll_req,
    input  logic [DATA_W-1:0] i_ll_data,
    output logic              o_ll_ack,
    input  logic              i_next_req,
    input  logic [DATA_W-1:0] i_next_data,
    output logic              o_next_ack,
    input  logic              i_clr_req,
    input  logic [4:0]        i_clr_row,
    output logic              o_clr_busy,
    output logic              o_clr_done,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_wdata,
    output logic              o_ram_we,
    input  logic [DATA_W-1:0] i_ram_rdata
);
    localparam logic [4:0]        NUM_ROWS_L = 5'(NUM_ROWS);
    localparam logic [ADDR_W-1:0] ROW_BASE_A = ADDR_W'(ROW_BASE);
    localparam logic [ADDR_W-1:0] SCORE_A    = ADDR_W'(SCORE_ADDR);
    localparam logic [ADDR_W-1:0] LL_A       = ADDR_W'(LEVEL_LINES_ADDR);
    localparam logic [ADDR_W-1:0] NEXT_A     = ADDR_W'(NEXT_ADDR);

    typedef enum logic [2:0] {StIdle, StRd, StRwait, StWr, StZero, StDone} state_e;

    state_e            r_state, w_state_d;
    logic [4:0]        r_k, w_k_d;
    logic [ADDR_W-1:0] r_addr, w_addr_d;
    logic [DATA_W-1:0] r_wdata, w_wdata_d;
    logic              r_we, w_we_d;
    logic              r_busy, w_busy_d;
    logic              r_done, w_done_d;
    logic [3:0]        r_ack, w_ack_d;   // {next, ll, score, row}

    logic [3:0]        w_req;
    logic              w_arb_en;
    logic              w_gnt_vld;
    logic [1:0]        w_gnt_idx;

    // A requester still showing its ack this cycle must not be granted again.
    assign w_req    = {i_next_req, i_ll_req, i_score_req, i_row_req} & ~r_ack;
    assign w_arb_en = ((r_state == StIdle) || (r_state == StDone)) && !i_clr_req;

`ifdef RR_ARB_EN
    logic [1:0] r_rr_ptr;

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = r_rr_ptr;
        for (int i = 3; i >= 0; i--) begin
            if (w_req[r_rr_ptr + 2'(i)]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = r_rr_ptr + 2'(i);
            end
        end
        w_gnt_vld = w_gnt_vld & w_arb_en;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rr_ptr <= 2'd0;
        end else if (w_gnt_vld) begin
            r_rr_ptr <= w_gnt_idx + 2'd1;
        end
    end
`else
    always_comb begin
        w_gnt_vld = w_arb_en && (w_req != 4'b0000);
        w_gnt_idx = 2'd0;
        if (w_req[0])      w_gnt_idx = 2'd0;
        else if (w_req[1]) w_gnt_idx = 2'd1;
        else if (w_req[2]) w_gnt_idx = 2'd2;
        else               w_gnt_idx = 2'd3;
    end
`endif

    always_comb begin
        w_state_d = r_state;
        w_k_d     = r_k;
        w_addr_d  = r_addr;
        w_wdata_d = r_wdata;
        w_we_d    = 1'b0;
        w_busy_d  = 1'b0;
        w_done_d  = 1'b0;
        w_ack_d   = 4'b0000;
        unique case (r_state)
            StIdle, StDone: begin
                w_state_d = StIdle;
                if (i_clr_req) begin
                    if (i_clr_row >= NUM_ROWS_L) begin
                        w_state_d = StDone;
                        w_done_d  = 1'b1;
                    end else if (i_clr_row == 5'd0) begin
                        w_state_d = StZero;
                        w_addr_d  = ROW_BASE_A;
                        w_wdata_d = '0;
                        w_we_d    = 1'b1;
                        w_busy_d  = 1'b1;
                    end else begin
                        w_state_d = StRd;
                        w_k_d     = i_clr_row;
                        w_addr_d  = ROW_BASE_A + ADDR_W'(i_clr_row - 5'd1);
                        w_busy_d  = 1'b1;
                    end
                end else if (w_gnt_vld) begin
                    w_ack_d[w_gnt_idx] = 1'b1;
                    case (w_gnt_idx)
                        2'd0: begin
                            if (i_row_idx < NUM_ROWS_L) begin
                                w_we_d    = 1'b1;
                                w_addr_d  = ROW_BASE_A + ADDR_W'(i_row_idx);
                                w_wdata_d = i_row_data;
                            end
                        end
                        2'd1: begin
                            w_we_d    = 1'b1;
                            w_addr_d  = SCORE_A;
                            w_wdata_d = i_score_data;
                        end
                        2'd2: begin
                            w_we_d    = 1'b1;
                            w_addr_d  = LL_A;
                            w_wdata_d = i_ll_data;
                        end
                        default: begin
                            w_we_d    = 1'b1;
                            w_addr_d  = NEXT_A;
                            w_wdata_d = i_next_data;
                        end
                    endcase
                end
            end
            StRd: begin
                w_state_d = StRwait;
                w_busy_d  = 1'b1;
            end
            StRwait: begin
                // Read data for row k-1 is on i_ram_rdata now; copy it down into row k.
                w_state_d = StWr;
                w_addr_d  = ROW_BASE_A + ADDR_W'(r_k);
                w_wdata_d = i_ram_rdata;
                w_we_d    = 1'b1;
                w_k_d     = r_k - 5'd1;
                w_busy_d  = 1'b1;
            end
            StWr: begin
                w_busy_d = 1'b1;
                if (r_k == 5'd0) begin
                    w_state_d = StZero;
                    w_addr_d  = ROW_BASE_A;
                    w_wdata_d = '0;
                    w_we_d    = 1'b1;
                end else begin
                    w_state_d = StRd;
                    w_addr_d  = ROW_BASE_A + ADDR_W'(r_k - 5'd1);
                end
            end
            StZero: begin
                w_state_d = StDone;
                w_done_d  = 1'b1;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
            r_k     <= 5'd0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ack   <= 4'b0000;
        end else begin
            r_state <= w_state_d;
            r_k     <= w_k_d;
            r_addr  <= w_addr_d;
            r_wdata <= w_wdata_d;
            r_we    <= w_we_d;
            r_busy  <= w_busy_d;
            r_done  <= w_done_d;
            r_ack   <= w_ack_d;
        end
    end

    assign o_row_ack   = r_ack[0];
    assign o_score_ack = r_ack[1];
    assign o_ll_ack    = r_ack[2];
    assign o_next_ack  = r_ack[3];
    assign o_clr_busy  = r_busy;
    assign o_clr_done  = r_done;
    assign o_ram_addr  = r_addr;
    assign o_ram_wdata = r_wdata;
    assign o_ram_we    = r_we;

endmodule

// File: tb/tb_display_ram_scheduler.sv
// Scoreboard bench for display_ram_scheduler: RAM model on port A, board-level reference model,
// write-event queue checked by an independent monitor.
module tb_display_ram_scheduler;
    localparam int DW = 30;
    localparam int AW = 12;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          row_req = 0, score_req = 0, ll_req = 0, next_req = 0, clr_req = 0;
    logic [4:0]    row_idx = '0, clr_row = '0;
    logic [DW-1:0] row_data = '0, score_data = '0, ll_data = '0, next_data = '0;
    logic          row_ack, score_ack, ll_ack, next_ack, clr_busy, clr_done, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic [DW-1:0] mem [0:31];

    wr_t           exp_q[$];
    wr_t           mon_e;
    logic [DW-1:0] board [0:19];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            last_gnt = 3;

    always #5 clk = ~clk;

    display_ram_scheduler dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_row_req    (row_req),
        .i_row_idx    (row_idx),
        .i_row_data   (row_data),
        .o_row_ack    (row_ack),
        .i_score_req  (score_req),
        .i_score_data (score_data),
        .o_score_ack  (score_ack),
        .i_ll_req     (ll_req),
        .i_ll_data    (ll_data),
        .o_ll_ack     (ll_ack),
        .i_next_req   (next_req),
        .i_next_data  (next_data),
        .o_next_ack   (next_ack),
        .i_clr_req    (clr_req),
        .i_clr_row    (clr_row),
        .o_clr_busy   (clr_busy),
        .o_clr_done   (clr_done),
        .o_ram_addr   (ram_addr),
        .o_ram_wdata  (ram_wdata),
        .o_ram_we     (ram_we),
        .i_ram_rdata  (ram_rdata)
    );

    // Synchronous RAM port A: one-cycle read latency, read-before-write.
    always @(posedge clk) begin
        if (ram_we && ram_addr < 32) mem[ram_addr[4:0]] <= ram_wdata;
        ram_rdata <= (ram_addr < 32) ? mem[ram_addr[4:0]] : '0;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic wr_t mk(input int unsigned a, input logic [DW-1:0] d);
        wr_t w;
        w.addr = AW'(a);
        w.data = d;
        return w;
    endfunction

    // Monitor: every port-A write must match the next expected write.
    always @(negedge clk) begin
        if (ram_we) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: addr %0d data %0h, expected no write",
                         ram_addr, ram_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 64'(ram_addr), 64'(mon_e.addr));
                check("wr_data", 64'(ram_wdata), 64'(mon_e.data));
            end
        end
    end

    task automatic release_reqs(input logic [3:0] m);
        if (m[0]) row_req = 0;
        if (m[1]) score_req = 0;
        if (m[2]) ll_req = 0;
        if (m[3]) next_req = 0;
    endtask

    // Raise the requesters in mask together, hold each through its ack cycle, check grant order.
    task automatic do_writes(input logic [3:0] mask, input logic [4:0] idx);
        logic [DW-1:0] d [4];
        int            order[$];
        logic [3:0]    got, drop;
        for (int i = 0; i < 4; i++) d[i] = DW'($urandom);
`ifdef RR_ARB_EN
        for (int i = 1; i <= 4; i++) begin
            int j = (last_gnt + i) % 4;
            if (mask[j]) order.push_back(j);
        end
        if (order.size() > 0) last_gnt = order[order.size()-1];
`else
        for (int j = 0; j < 4; j++) if (mask[j]) order.push_back(j);
`endif
        foreach (order[i]) begin
            case (order[i])
                0: if (idx < 20) begin
                    exp_q.push_back(mk(2 + idx, d[0]));
                    board[idx] = d[0];
                end
                1: exp_q.push_back(mk(1, d[1]));
                2: exp_q.push_back(mk(0, d[2]));
                default: exp_q.push_back(mk(22, d[3]));
            endcase
        end
        row_idx = idx; row_data = d[0]; score_data = d[1]; ll_data = d[2]; next_data = d[3];
        row_req = mask[0]; score_req = mask[1]; ll_req = mask[2]; next_req = mask[3];
        drop = 4'b0000;
        for (int c = 0; c < order.size(); c++) begin
            @(posedge clk); #1;
            release_reqs(drop);
            got = {next_ack, ll_ack, score_ack, row_ack};
            check("ack_seq", 64'(got), 64'(1) << order[c]);
            drop = got;
        end
        @(posedge clk); #1;
        release_reqs(4'b1111);
        check("ack_once", 64'({next_ack, ll_ack, score_ack, row_ack}), 64'(0));
        check("we_drop", 64'(ram_we), 64'(0));
    endtask

    task automatic do_clear(input logic [4:0] r, input bit with_score);
        logic [DW-1:0] sd;
        int            lat, expl;
        sd = DW'($urandom);
        if (r < 20) begin
            for (int k = r; k >= 1; k--) begin
                exp_q.push_back(mk(2 + k, board[k-1]));
                board[k] = board[k-1];
            end
            exp_q.push_back(mk(2, '0));
            board[0] = '0;
            expl = 3 * r + 2;
        end else begin
            expl = 1;
        end
        if (with_score) begin
            exp_q.push_back(mk(1, sd));
            score_req = 1; score_data = sd;
`ifdef RR_ARB_EN
            last_gnt = 1;
`endif
        end
        clr_req = 1; clr_row = r;
        @(posedge clk); #1;
        clr_req = 0;
        lat = 1;
        check("busy_start", 64'(clr_busy), 64'(r < 20));
        while (!clr_done && lat < 80) begin
            @(posedge clk); #1;
            lat++;
        end
        check("done_latency", 64'(lat), 64'(expl));
        check("busy_at_done", 64'(clr_busy), 64'(0));
        @(posedge clk); #1;
        check("done_pulse", 64'(clr_done), 64'(0));
        if (with_score) check("score_after_clr", 64'(score_ack), 64'(1));
        @(posedge clk); #1;
        score_req = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        bit saw_done;
        repeat (3) @(posedge clk);
        #1;
        check("rst_we", 64'(ram_we), 64'(0));
        check("rst_addr", 64'(ram_addr), 64'(0));
        check("rst_wdata", 64'(ram_wdata), 64'(0));
        check("rst_acks", 64'({next_ack, ll_ack, score_ack, row_ack}), 64'(0));
        check("rst_busy_done", 64'({clr_busy, clr_done}), 64'(0));
        rst = 0;

        for (int i = 0; i < 20; i++) do_writes(4'b0001, 5'(i));
        do_writes(4'b0010, 5'd0);
        do_writes(4'b1011, 5'd5);
        repeat (3) do_writes(4'b1111, 5'($urandom_range(0, 19)));
        for (int i = 0; i < 4; i++) begin
            row_data = DW'(i + 1);
            do_writes(4'b0001, 5'(i));
        end
        do_clear(5'd3, 1'b1);
        do_writes(4'b0001, 5'd20);
        do_clear(5'd0, 1'b0);
        do_clear(5'd21, 1'b0);

        // Reset during the RWAIT cycle of a clear of row 5.
        clr_req = 1; clr_row = 5'd5;
        @(posedge clk); #1;
        clr_req = 0;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        check("rst_mid_busy", 64'(clr_busy), 64'(0));
        check("rst_mid_we", 64'(ram_we), 64'(0));
        rst = 0;
        last_gnt = 3;
        saw_done = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (clr_done) saw_done = 1;
        end
        check("rst_no_done", 64'(saw_done), 64'(0));

        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 3) == 0)
                do_clear(5'($urandom_range(0, 21)), 1'($urandom_range(0, 1)));
            else
                do_writes(4'($urandom_range(1, 15)), 5'($urandom_range(0, 21)));
        end

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("queue_empty", 64'(exp_q.size()), 64'(0));
        for (int i = 0; i < 20; i++) check("board_row", 64'(mem[2+i]), 64'(board[i]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
